online_detector: RTL and testbench
==================================

ONLINE_DETECTOR -- requirements
Module: online_detector

Interface
REQ-001 Parameter WINDOW, 100000, clk cycles per measurement window (1 ms at 100 MHz).
REQ-002 Parameter MIN_CNT, 16'd700, lowest edge count per window accepted as a valid source.
REQ-003 Parameter MAX_CNT, 16'd1300, highest edge count per window accepted as a valid source.
REQ-004 Parameter LOCK_WIN, 4, consecutive good windows needed to go online (range 1..15).
REQ-005 Parameter LOSS_WIN, 2, consecutive bad windows needed to go offline (range 1..15).
REQ-006 clk  input  1  local free-running on-board reference clock; the only clock.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 hdmi_tog  input  1  asynchronous toggle from the HDMI clock domain, i.e. TMDS clock divided down; each transition is one edge.
REQ-009 cable_5v  input  1  asynchronous HDMI +5V detect level; 1 = cable powered.
REQ-010 online  output  1  registered select for the downstream BUFGMUX stage; 1 = use HDMI clocks.
REQ-011 meas_cnt  output  16  edge count of the last completed window.
REQ-012 meas_valid  output  1  one-cycle pulse when meas_cnt updates.
REQ-013 state  output  2  FSM state: 0 OFFLINE, 1 ACQUIRE, 2 ONLINE, 3 LOSING.

Function
REQ-014 The block SHALL pass hdmi_tog through a 3-flop synchronizer and SHALL flag an edge when flop 2 differs from flop 3.
REQ-015 The block SHALL pass cable_5v through a 2-flop synchronizer, giving v5_s.
REQ-016 The window counter SHALL count 0..WINDOW-1 and wrap; the terminal cycle is the cycle where it equals WINDOW-1.
REQ-017 The edge counter SHALL increment per flagged edge and SHALL saturate at 16'hFFFF.
REQ-018 On the terminal cycle, meas_cnt SHALL load the edge count including any edge flagged that cycle (saturated); the edge counter SHALL clear to 0; meas_valid SHALL pulse on the next cycle, coincident with the new meas_cnt.
REQ-019 A window SHALL be good iff MIN_CNT <= count <= MAX_CNT and v5_s = 1 on the terminal cycle; otherwise it is bad.
REQ-020 The FSM SHALL evaluate only on the terminal cycle, except REQ-025. A consecutive-window counter (4 bits) tracks progress.
REQ-021 OFFLINE: on good -> ACQUIRE, run = 1; if LOCK_WIN = 1 -> ONLINE directly. On bad -> stay.
REQ-022 ACQUIRE: on good, run+1; when run reaches LOCK_WIN -> ONLINE, run = 0. On bad -> OFFLINE, run = 0.
REQ-023 ONLINE: on bad -> LOSING, run = 1; if LOSS_WIN = 1 -> OFFLINE directly. On good -> stay.
REQ-024 LOSING: on bad, run+1; when run reaches LOSS_WIN -> OFFLINE, run = 0. On good -> ONLINE, run = 0.
REQ-025 When v5_s = 0 in any state, the FSM SHALL go to OFFLINE on the next clock, regardless of window position; the window and edge counters continue.
REQ-026 online SHALL be a flop that is 1 exactly when the registered state is ONLINE or LOSING; online SHALL NOT glitch.
REQ-027 The output latency from the FSM entering ONLINE to online = 1 SHALL be 0 cycles. Both are registered on the same edge.

Reset
REQ-028 While rst_n = 0, all synchronizer flops, counters, and run SHALL be 0. meas_cnt SHALL be 0, meas_valid 0, state OFFLINE, online 0.
REQ-029 Deassertion of rst_n SHALL start window 0 on the first clk edge after release; asserting rst_n mid-window SHALL discard that window.

Verification (WINDOW=1000, MIN_CNT=80, MAX_CNT=120, LOCK_WIN=4, LOSS_WIN=2)
REQ-030 Reset with toggles running -> online=0, meas_cnt=0, state=0 throughout reset; first meas_valid exactly 1000 cycles after release.
REQ-031 cable_5v=1, hdmi_tog toggling every 10 clk -> every window meas_cnt=100; state goes 1 after window 1; online=1 after the terminal cycle of window 4.
REQ-032 Online, then hdmi_tog stopped -> meas_cnt=0; state=3 after one window; online=0 after the second bad window; restart after one bad window -> state=2, online stays 1.
REQ-033 "Ghost" slow clock, toggle every 50 clk -> meas_cnt=20; online never asserts. Toggle every 2 clk -> 500 > MAX; online never asserts.
REQ-034 Online, cable_5v drops mid-window -> online=0 within 3 clk of the drop; reacquisition after 5V returns needs 4 fresh good windows.
REQ-035 ACQUIRE with 3 good windows, then 1 bad, then good -> state returns to 0, then 1; online first asserts only after 4 further consecutive good windows.

Source files
------------

// File: rtl/online_detector_if.sv
// online_detector_if
//   Groups the measurement-side signals of the HDMI clock presence detector.
//   hdmi_tog   : asynchronous toggle from the HDMI domain, one edge per transition
//   cable_5v   : asynchronous +5V cable detect level, 1 = powered
//   online     : registered clock-select, 1 = use HDMI clocks
//   meas_cnt   : edge count of the last completed window
//   meas_valid : one-cycle pulse when meas_cnt updates
//   state      : FSM state, 0 OFFLINE, 1 ACQUIRE, 2 ONLINE, 3 LOSING
// Handshake semantics: there is no back-pressure. meas_valid is a pure
// valid strobe with no ready; a consumer must capture meas_cnt in the cycle
// meas_valid is high, and meas_cnt holds its value until the next strobe.
interface online_detector_if;
   logic        hdmi_tog;
   logic        cable_5v;
   logic        online;
   logic [15:0] meas_cnt;
   logic        meas_valid;
   logic [1:0]  state;

   modport master (
      output hdmi_tog,
      output cable_5v,
      input  online,
      input  meas_cnt,
      input  meas_valid,
      input  state
   );

   modport slave (
      input  hdmi_tog,
      input  cable_5v,
      output online,
      output meas_cnt,
      output meas_valid,
      output state
   );
endinterface

// File: rtl/online_detector.sv
// online_detector
//   Measures the HDMI clock frequency by counting toggle edges over a fixed
//   window of local clk cycles, and decides with hysteresis whether the HDMI
//   clock is trustworthy enough to select downstream.
//   clk   : local free-running reference clock, the only clock
//   rst_n : asynchronous active-low reset
//   bus   : online_detector_if.slave (toggle/5V inputs, select and measurement outputs)
module online_detector #(
   parameter int          WINDOW   = 100000,
   parameter logic [15:0] MIN_CNT  = 16'd700,
   parameter logic [15:0] MAX_CNT  = 16'd1300,
   parameter int          LOCK_WIN = 4,
   parameter int          LOSS_WIN = 2
) (
   input logic               clk,
   input logic               rst_n,
   online_detector_if.slave  bus
);

   localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   typedef enum logic [1:0] {
      ST_OFFLINE = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_ONLINE  = 2'd2,
      ST_LOSING  = 2'd3
   } state_t;

   // Synchronizers: tog_sync_q[0] is flop 1, [2] is flop 3.
   logic [2:0]       tog_sync_q, tog_sync_d;
   logic [1:0]       v5_sync_q, v5_sync_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [15:0]      edge_cnt_q, edge_cnt_d;
   logic [15:0]      meas_cnt_q, meas_cnt_d;
   logic             meas_valid_q, meas_valid_d;
   state_t           state_q, state_d;
   logic [3:0]       run_q, run_d;
   logic             online_q, online_d;

   logic             tog_edge;
   logic             v5_s;
   logic             terminal;
   logic [15:0]      edge_sum;
   logic             good;

   always_comb begin
      tog_sync_d = {tog_sync_q[1:0], bus.hdmi_tog};
      v5_sync_d  = {v5_sync_q[0], bus.cable_5v};
      tog_edge   = tog_sync_q[1] ^ tog_sync_q[2];
      v5_s       = v5_sync_q[1];
      terminal   = (win_cnt_q == WIN_W'(WINDOW - 1));

      // Count including an edge flagged in this very cycle, saturating.
      edge_sum = edge_cnt_q;
      if (tog_edge && (edge_cnt_q != 16'hFFFF)) begin
         edge_sum = edge_cnt_q + 16'd1;
      end

      good = (edge_sum >= MIN_CNT) && (edge_sum <= MAX_CNT) && v5_s;

      win_cnt_d    = terminal ? '0 : win_cnt_q + WIN_W'(1);
      edge_cnt_d   = terminal ? 16'd0 : edge_sum;
      meas_cnt_d   = terminal ? edge_sum : meas_cnt_q;
      meas_valid_d = terminal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tog_sync_q   <= '0;
         v5_sync_q    <= '0;
         win_cnt_q    <= '0;
         edge_cnt_q   <= '0;
         meas_cnt_q   <= '0;
         meas_valid_q <= 1'b0;
      end else begin
         tog_sync_q   <= tog_sync_d;
         v5_sync_q    <= v5_sync_d;
         win_cnt_q    <= win_cnt_d;
         edge_cnt_q   <= edge_cnt_d;
         meas_cnt_q   <= meas_cnt_d;
         meas_valid_q <= meas_valid_d;
      end
   end

   // Next-state logic. Loss of 5V overrides everything and acts immediately;
   // otherwise the FSM only moves on the terminal cycle of a window.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      if (!v5_s) begin
         state_d = ST_OFFLINE;
         run_d   = 4'd0;
      end else if (terminal) begin
         case (state_q)
            ST_OFFLINE: begin
               if (good) begin
                  if (LOCK_WIN == 1) begin
                     state_d = ST_ONLINE;
                     run_d   = 4'd0;
                  end else begin
                     state_d = ST_ACQUIRE;
                     run_d   = 4'd1;
                  end
               end
            end
            ST_ACQUIRE: begin
               if (good) begin
                  if ((run_q + 4'd1) >= 4'(LOCK_WIN)) begin
                     state_d = ST_ONLINE;
                     run_d   = 4'd0;
                  end else begin
                     run_d = run_q + 4'd1;
                  end
               end else begin
                  state_d = ST_OFFLINE;
                  run_d   = 4'd0;
               end
            end
            ST_ONLINE: begin
               if (!good) begin
                  if (LOSS_WIN == 1) begin
                     state_d = ST_OFFLINE;
                     run_d   = 4'd0;
                  end else begin
                     state_d = ST_LOSING;
                     run_d   = 4'd1;
                  end
               end
            end
            default: begin // ST_LOSING
               if (!good) begin
                  if ((run_q + 4'd1) >= 4'(LOSS_WIN)) begin
                     state_d = ST_OFFLINE;
                     run_d   = 4'd0;
                  end else begin
                     run_d = run_q + 4'd1;
                  end
               end else begin
                  state_d = ST_ONLINE;
                  run_d   = 4'd0;
               end
            end
         endcase
      end
      // Decoded from the next state so online flips on the same edge as state.
      online_d = (state_d == ST_ONLINE) || (state_d == ST_LOSING);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFFLINE;
         run_q    <= 4'd0;
         online_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         online_q <= online_d;
      end
   end

   assign bus.online     = online_q;
   assign bus.meas_cnt   = meas_cnt_q;
   assign bus.meas_valid = meas_valid_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_online_detector.sv
module tb_online_detector;

   localparam int WINDOW = 1000;

   typedef struct {
      int          period;   // hdmi_tog toggles every period clk, 0 = stopped
      logic        v5;
      logic        chk_cnt;  // 0 for windows straddling a rate change
      logic [15:0] cnt;
      logic [1:0]  st;
      logic        onl;
   } vec_t;

   logic clk;
   logic rst_n;
   int   tog_period;
   int   tests;
   int   fails;
   vec_t tbl[40];
   int   n_rows;
   logic [19:0] exp_q[$];

   online_detector_if bus();

   online_detector #(
      .WINDOW   (WINDOW),
      .MIN_CNT  (16'd80),
      .MAX_CNT  (16'd120),
      .LOCK_WIN (4),
      .LOSS_WIN (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // toggle source
   initial begin
      int tog_cnt;
      tog_cnt = 0;
      bus.hdmi_tog = 1'b0;
      forever begin
         @(negedge clk);
         if (tog_period > 0) begin
            tog_cnt++;
            if (tog_cnt >= tog_period) begin
               tog_cnt = 0;
               bus.hdmi_tog = ~bus.hdmi_tog;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input int p, input logic v, input logic c, input logic [15:0] n,
                      input logic [1:0] s, input logic o);
      tbl[n_rows].period  = p;
      tbl[n_rows].v5      = v;
      tbl[n_rows].chk_cnt = c;
      tbl[n_rows].cnt     = n;
      tbl[n_rows].st      = s;
      tbl[n_rows].onl     = o;
      n_rows++;
   endtask

   task automatic wait_window(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < WINDOW + 500; i++) begin
         @(negedge clk);
         if (bus.meas_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL window_timeout: got no meas_valid expected one within %0d cycles", WINDOW + 500);
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      bit ok;
      logic [19:0] e;
      for (int r = lo; r <= hi; r++) begin
         tog_period   = tbl[r].period;
         bus.cable_5v = tbl[r].v5;
         exp_q.push_back({tbl[r].chk_cnt, tbl[r].onl, tbl[r].st, tbl[r].cnt});
         wait_window(ok);
         e = exp_q.pop_front();
         if (ok) begin
            if (e[19]) check($sformatf("row%0d_meas_cnt", r), int'(bus.meas_cnt), int'(e[15:0]));
            check($sformatf("row%0d_state", r), int'(bus.state), int'(e[17:16]));
            check($sformatf("row%0d_online", r), int'(bus.online), int'(e[18]));
         end
      end
   endtask

   // Hold reset, check outputs throughout, release, and time the first window.
   task automatic reset_and_first_window(input string tag);
      int k;
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check({tag, "_rst_state"}, int'(bus.state), 0);
         check({tag, "_rst_online"}, int'(bus.online), 0);
         check({tag, "_rst_meas_cnt"}, int'(bus.meas_cnt), 0);
         check({tag, "_rst_meas_valid"}, int'(bus.meas_valid), 0);
      end
      rst_n = 1'b1;
      k = 0;
      for (int i = 1; i <= WINDOW + 200; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.meas_valid) begin
            k = i;
            break;
         end
      end
      check({tag, "_first_valid_cycle"}, k, WINDOW);
      check({tag, "_win1_state"}, int'(bus.state), 1);
      check({tag, "_win1_online"}, int'(bus.online), 0);
   endtask

   initial begin
      bit ok;
      int k;
      tests        = 0;
      fails        = 0;
      n_rows       = 0;
      rst_n        = 1'b0;
      tog_period   = 10;
      bus.cable_5v = 1'b1;

      // {period, v5, chk_cnt, cnt, state, online}
      add(10, 1, 1, 100, 1, 0);  // 0  window 2
      add(10, 1, 1, 100, 1, 0);  // 1  window 3
      add(10, 1, 1, 100, 2, 1);  // 2  window 4 -> online
      add(10, 1, 1, 100, 2, 1);  // 3
      add( 0, 1, 0,   0, 3, 1);  // 4  toggles stopped -> losing
      add( 0, 1, 1,   0, 0, 0);  // 5  second bad -> offline
      add(10, 1, 0,   0, 1, 0);  // 6
      add(10, 1, 1, 100, 1, 0);  // 7
      add(10, 1, 1, 100, 1, 0);  // 8
      add(10, 1, 1, 100, 2, 1);  // 9
      add( 0, 1, 0,   0, 3, 1);  // 10 one bad window
      add(10, 1, 0,   0, 2, 1);  // 11 recovers straight to online
      add(10, 1, 1, 100, 2, 1);  // 12
      add(50, 1, 0,   0, 3, 1);  // 13 ghost slow clock
      add(50, 1, 1,  20, 0, 0);  // 14
      add(50, 1, 1,  20, 0, 0);  // 15
      add( 2, 1, 0,   0, 0, 0);  // 16 ghost fast clock
      add( 2, 1, 1, 500, 0, 0);  // 17
      add(10, 1, 0,   0, 1, 0);  // 18
      add(10, 1, 1, 100, 1, 0);  // 19
      add(10, 1, 1, 100, 1, 0);  // 20
      add(10, 1, 1, 100, 2, 1);  // 21
      add(10, 1, 1, 100, 1, 0);  // 22 after 5V drop window
      add(10, 1, 1, 100, 1, 0);  // 23
      add(10, 1, 1, 100, 2, 1);  // 24
      add( 0, 1, 0,   0, 3, 1);  // 25
      add( 0, 1, 1,   0, 0, 0);  // 26
      add(10, 1, 0,   0, 1, 0);  // 27
      add(10, 1, 1, 100, 1, 0);  // 28
      add(10, 1, 1, 100, 1, 0);  // 29 three good windows in ACQUIRE
      add(50, 1, 0,   0, 0, 0);  // 30 one bad -> offline
      add(10, 1, 0,   0, 1, 0);  // 31
      add(10, 1, 1, 100, 1, 0);  // 32
      add(10, 1, 1, 100, 1, 0);  // 33
      add(10, 1, 1, 100, 2, 1);  // 34 fourth fresh good window

      repeat (3) @(negedge clk);
      reset_and_first_window("por");
      run_rows(0, 21);

      // 5V drop mid-window while online
      repeat (400) @(negedge clk);
      bus.cable_5v = 1'b0;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!bus.online) begin
            k = i;
            break;
         end
      end
      check("v5_drop_latency", k, 3);
      check("v5_drop_state", int'(bus.state), 0);
      repeat (20) @(negedge clk);
      bus.cable_5v = 1'b1;
      wait_window(ok);
      if (ok) begin
         check("v5_window_meas_cnt", int'(bus.meas_cnt), 100);
         check("v5_window_state", int'(bus.state), 1);
         check("v5_window_online", int'(bus.online), 0);
         @(negedge clk);
         check("meas_valid_one_cycle", int'(bus.meas_valid), 0);
      end

      run_rows(22, 34);

      // reset in the middle of a window while online
      repeat (300) @(negedge clk);
      reset_and_first_window("mid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
